// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths and the fetch-stage state encoding.
package cpu_pkg;

  localparam int WORD_W  = 32;
  localparam int INSTR_W = 32;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    HALT  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: captures a fetched instruction and its PC, with flush priority.
module if_id_reg
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               flush,
  input  logic [INSTR_W-1:0] next_instr,
  input  logic [WORD_W-1:0]  next_pc,
  output logic [INSTR_W-1:0] instr,
  output logic [WORD_W-1:0]  pc,
  output logic               valid
);

  // A flush only drops the valid bit; stale data is harmless once invalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr <= '0;
      pc    <= '0;
      valid <= 1'b0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (enable) begin
      instr <= next_instr;
      pc    <= next_pc;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Word-addressed instruction fetch: PC register, run/stall/halt control and redirect handling.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int              NUM_INSTR = 11,
  parameter logic [WORD_W-1:0] RESET_PC = '0
) (
  input  logic               i_clk,
  input  logic               i_rst,
  output logic [WORD_W-1:0]  o_imem_pc,
  input  logic [INSTR_W-1:0] i_imem_instr,
  input  logic               i_redirect,
  input  logic [WORD_W-1:0]  i_target,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [INSTR_W-1:0] o_instr,
  output logic [WORD_W-1:0]  o_pc,
  output logic               o_halted,
  output logic               o_bad_target
);

  localparam logic [WORD_W-1:0] NUM_W = WORD_W'(NUM_INSTR);

  logic [WORD_W-1:0] pc;
  fetch_state_e      state;
  logic              adv;
  logic              at_last;
  logic              target_bad;
  logic              flush;

  assign o_imem_pc  = pc;
  assign o_halted   = (state == HALT);
  assign adv        = !o_halted && (!o_valid || i_ready);
  assign at_last    = (pc == NUM_W - 1);
  assign target_bad = (i_target >= NUM_W);
  // Draining a halted stage is a flush that waits for decode to take the last word.
  assign flush      = i_redirect || (o_halted && i_ready);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pc           <= RESET_PC;
      state        <= RUN;
      o_bad_target <= 1'b0;
    end else if (i_redirect) begin
      pc    <= i_target;
      state <= target_bad ? HALT : RUN;
      if (target_bad) begin
        o_bad_target <= 1'b1;
      end
    end else if (adv) begin
      pc    <= pc + 32'd1;
      state <= at_last ? HALT : RUN;
    end else if (!o_halted) begin
      state <= STALL;
    end
  end

  if_id_reg u_if_id (
    .clk        (i_clk),
    .rst        (i_rst),
    .enable     (adv),
    .flush      (flush),
    .next_instr (i_imem_instr),
    .next_pc    (pc),
    .instr      (o_instr),
    .pc         (o_pc),
    .valid      (o_valid)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage with a behavioural instruction memory and a fetch scoreboard.
module tb_fetch_stage;

  localparam int NUM_INSTR = 11;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_pc;
  logic [31:0] imem_instr;
  logic        redirect;
  logic [31:0] target;
  logic        valid;
  logic        ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        halted;
  logic        bad_target;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] sb_queue[$];

  always #5 clk = ~clk;

  // Memory word i holds 0x100+i; out-of-range reads return a poison pattern.
  assign imem_instr = (imem_pc < NUM_INSTR) ? (32'h100 + imem_pc) : 32'hDEAD_BEEF;

  fetch_stage #(.NUM_INSTR(NUM_INSTR), .RESET_PC(32'd0)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .o_imem_pc    (imem_pc),
    .i_imem_instr (imem_instr),
    .i_redirect   (redirect),
    .i_target     (target),
    .o_valid      (valid),
    .i_ready      (ready),
    .o_instr      (instr),
    .o_pc         (pc),
    .o_halted     (halted),
    .o_bad_target (bad_target)
  );

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, then sample just after the rising edge.
  task automatic applyStimulus(input logic r, input logic rd, input logic [31:0] tg, input logic rdy);
    rst      = r;
    redirect = rd;
    target   = tg;
    ready    = rdy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cycles;
    logic [63:0] exp_word;

    rst = 1'b1; redirect = 1'b0; target = '0; ready = 1'b0;
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("reset_valid",  valid,      0);
    checkOutput("reset_pc_out", imem_pc,    0);
    checkOutput("reset_halted", halted,     0);
    checkOutput("reset_bad",    bad_target, 0);
    checkOutput("reset_instr",  {instr, pc}, 64'd0);

    // Straight-line run: every word pushed into the scoreboard, popped as decode accepts it.
    for (int i = 0; i < NUM_INSTR; i++) sb_queue.push_back({32'h100 + 32'(i), 32'(i)});
    cycles = 0;
    while (sb_queue.size() > 0 && cycles < 30) begin
      applyStimulus(0, 0, 0, 1);
      cycles++;
      if (!halted) checkOutput("imem_pc_in_range", imem_pc <= NUM_INSTR - 1, 1);
      if (valid) begin
        exp_word = sb_queue.pop_front();
        checkOutput("seq_instr_pc", {instr, pc}, exp_word);
      end
    end
    checkOutput("seq_budget", sb_queue.size(), 0);
    checkOutput("seq_cycles", cycles, NUM_INSTR);
    checkOutput("halt_after_last", halted, 1);
    checkOutput("halt_pc_frozen", imem_pc, NUM_INSTR);
    applyStimulus(0, 0, 0, 1);
    checkOutput("halt_drain_valid", valid, 0);
    checkOutput("halt_drain_pc", imem_pc, NUM_INSTR);
    applyStimulus(0, 0, 0, 1);
    checkOutput("halt_still", {31'd0, halted, 31'd0, valid}, {31'd0, 1'b1, 32'd0});

    // Redirect out of halt resumes fetch.
    applyStimulus(0, 1, 1, 1);
    checkOutput("resume_halted", halted, 0);
    checkOutput("resume_bubble", valid, 0);
    checkOutput("resume_imem_pc", imem_pc, 1);
    applyStimulus(0, 0, 0, 1);
    checkOutput("resume_first", {valid, instr, pc}, {1'b1, 32'h101, 32'd1});
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 0, 0, 1);
    checkOutput("pre_stall", {instr, pc}, {32'h103, 32'd3});

    // Four-cycle stall at o_pc=3.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0, 0);
      checkOutput("stall_hold", {valid, instr, pc}, {1'b1, 32'h103, 32'd3});
      checkOutput("stall_imem_pc", imem_pc, 4);
    end
    applyStimulus(0, 0, 0, 1);
    checkOutput("stall_release", {instr, pc}, {32'h104, 32'd4});

    // Redirect during a stall at o_pc=2.
    applyStimulus(0, 1, 2, 1);
    applyStimulus(0, 0, 0, 0);
    checkOutput("setup_pc2", {valid, pc}, {1'b1, 32'd2});
    applyStimulus(0, 1, 7, 0);
    checkOutput("redir_flush", valid, 0);
    checkOutput("redir_imem_pc", imem_pc, 7);
    applyStimulus(0, 0, 0, 0);
    checkOutput("redir_target", {valid, instr, pc}, {1'b1, 32'h107, 32'd7});

    // Reset during a stall at o_pc=5 discards the held word.
    applyStimulus(0, 1, 5, 0);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("stall_at5", {valid, pc}, {1'b1, 32'd5});
    applyStimulus(1, 0, 0, 0);
    checkOutput("rst_stall_valid", valid, 0);
    checkOutput("rst_stall_imem_pc", imem_pc, 0);
    applyStimulus(0, 0, 0, 1);
    checkOutput("rst_first_fetch", {valid, instr, pc}, {1'b1, 32'h100, 32'd0});

    // Out-of-range redirect target.
    applyStimulus(0, 1, 20, 1);
    checkOutput("bad_flags", {valid, halted, bad_target}, 3'b011);
    checkOutput("bad_imem_pc", imem_pc, 20);
    applyStimulus(0, 0, 0, 1);
    checkOutput("bad_sticky", {valid, halted, bad_target}, 3'b011);
    checkOutput("bad_pc_frozen", imem_pc, 20);
    applyStimulus(1, 0, 0, 0);
    checkOutput("bad_cleared", {valid, halted, bad_target}, 3'b000);
    checkOutput("bad_rst_imem_pc", imem_pc, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
